// File: rtl/mux_rr_arb.sv
// Round-robin N-channel byte-lane mux with burst hold and a registered output.
// Optional burst limit is enabled by defining MUX_BURST_LIMIT_EN.
//   state | meaning
//   IDLE  | no channel owns the lane
//   HOLD  | channel cur owns the lane while its valid_in stays high
module mux_rr_arb #(
  parameter int DATA_W    = 8,
  parameter int NCH       = 4,
  parameter int MAX_BURST = 16,
  parameter int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [NCH*DATA_W-1:0] data_in,
  input  logic [NCH-1:0]        valid_in,
  output logic [NCH-1:0]        grant_out,
  output logic [DATA_W-1:0]     data_out,
  output logic                  valid_out,
  output logic [CH_W-1:0]       chan_out
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   cur, cur_nxt;
  logic [CH_W-1:0]   ptr, ptr_nxt;
  logic [CH_W-1:0]   scan_start, scan_idx;
  logic [CH_W-1:0]   win, sel;
  logic              win_vld, sel_vld;
  logic              keep, limit_hit;
  logic [DATA_W-1:0] sel_data;

  function automatic logic [CH_W-1:0] next_idx(input logic [CH_W-1:0] c);
    if (c == CH_W'(NCH - 1)) return '0;
    return c + CH_W'(1);
  endfunction

`ifdef MUX_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] cnt;

  assign limit_hit = (cnt == CNT_W'(MAX_BURST));

  always_ff @(posedge clk_2f) begin
    if (reset)         cnt <= '0;
    else if (!sel_vld) cnt <= '0;
    else if (keep)     cnt <= cnt + CNT_W'(1);
    else               cnt <= CNT_W'(1);
  end
`else
  // MAX_BURST is meaningless here; the term is constant false for legal values.
  assign limit_hit = (MAX_BURST < 1);
`endif

  always_comb begin
    state_nxt  = state;
    cur_nxt    = cur;
    ptr_nxt    = ptr;
    keep       = 1'b0;
    scan_start = ptr;
    win        = '0;
    win_vld    = 1'b0;
    scan_idx   = '0;
    sel        = '0;
    sel_vld    = 1'b0;
    sel_data   = '0;
    grant_out  = '0;

    if (state == HOLD) begin
      if (valid_in[cur] && !limit_hit) begin
        keep = 1'b1;
      end else begin
        // Release moves the pointer past cur before the same-cycle rescan.
        ptr_nxt    = next_idx(cur);
        scan_start = ptr_nxt;
      end
    end

    scan_idx = scan_start;
    for (int i = 0; i < NCH; i++) begin
      if (!win_vld && valid_in[scan_idx]) begin
        win_vld = 1'b1;
        win     = scan_idx;
      end
      scan_idx = next_idx(scan_idx);
    end

    if (keep) begin
      sel     = cur;
      sel_vld = 1'b1;
    end else begin
      sel     = win;
      sel_vld = win_vld;
    end
    if (reset) sel_vld = 1'b0;

    for (int k = 0; k < NCH; k++) begin
      grant_out[k] = sel_vld && (sel == CH_W'(k));
      if (sel == CH_W'(k)) sel_data = data_in[k*DATA_W +: DATA_W];
    end

    state_nxt = sel_vld ? HOLD : IDLE;
    if (sel_vld) cur_nxt = sel;
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state     <= IDLE;
      cur       <= '0;
      ptr       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      chan_out  <= '0;
    end else begin
      state     <= state_nxt;
      cur       <= cur_nxt;
      ptr       <= ptr_nxt;
      valid_out <= sel_vld;
      data_out  <= sel_vld ? sel_data : '0;
      chan_out  <= sel_vld ? sel : '0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arb.sv
// Self-checking bench for mux_rr_arb: directed steps plus random traffic
// against a cycle-level arbitration model.
module tb_mux_rr_arb;
  localparam int DATA_W    = 8;
  localparam int NCH       = 4;
  localparam int MAX_BURST = 4;
  localparam int CH_W      = 2;
`ifdef MUX_BURST_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic                  clk_2f = 1'b0;
  logic                  reset;
  logic [NCH*DATA_W-1:0] data_in;
  logic [NCH-1:0]        valid_in;
  logic [NCH-1:0]        grant_out;
  logic [DATA_W-1:0]     data_out;
  logic                  valid_out;
  logic [CH_W-1:0]       chan_out;

  mux_rr_arb #(.DATA_W(DATA_W), .NCH(NCH), .MAX_BURST(MAX_BURST), .CH_W(CH_W)) dut (
    .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .grant_out(grant_out), .data_out(data_out), .valid_out(valid_out), .chan_out(chan_out)
  );

  always #5 clk_2f = ~clk_2f;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: who owns the lane, round-robin start, words in current burst.
  bit          m_busy;
  int          m_cur, m_ptr, m_cnt;
  logic [7:0]  e_data;
  logic        e_valid;
  logic [1:0]  e_chan;
  int          last_w;

  function automatic int rr_pick(input logic [NCH-1:0] v, input int start);
    for (int i = 0; i < NCH; i++)
      if (v[(start + i) % NCH]) return (start + i) % NCH;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [NCH-1:0] v, input logic [NCH*DATA_W-1:0] d);
    int w, newptr;
    bit cont;
    reset = r; valid_in = v; data_in = d;
    @(negedge clk_2f);
    w = -1; cont = 1'b0; newptr = m_ptr;
    if (!r) begin
      if (!m_busy) w = rr_pick(v, m_ptr);
      else if (v[m_cur] && !(LIM && m_cnt == MAX_BURST)) begin w = m_cur; cont = 1'b1; end
      else begin newptr = (m_cur + 1) % NCH; w = rr_pick(v, newptr); end
    end
    check("grant_out", {28'd0, grant_out}, (w < 0) ? 32'd0 : (32'd1 << w));
    @(posedge clk_2f);
    if (r) begin
      m_busy = 0; m_cur = 0; m_ptr = 0; m_cnt = 0;
      e_valid = 0; e_data = 0; e_chan = 0;
    end else begin
      m_ptr = newptr;
      if (w >= 0) begin
        m_cnt = cont ? m_cnt + 1 : 1;
        m_busy = 1; m_cur = w;
        e_valid = 1; e_data = d[w*DATA_W +: DATA_W]; e_chan = 2'(w);
      end else begin
        m_busy = 0; m_cnt = 0;
        e_valid = 0; e_data = 0; e_chan = 0;
      end
    end
    last_w = w;
    #1;
    check("valid_out", {31'd0, valid_out}, {31'd0, e_valid});
    check("data_out", {24'd0, data_out}, {24'd0, e_data});
    if (e_valid || r) check("chan_out", {30'd0, chan_out}, {30'd0, e_chan});
  endtask

  function automatic logic [31:0] pack(input logic [7:0] a, b, c, e);
    return {e, c, b, a};
  endfunction

  logic [7:0] rd [NCH];
  logic [NCH-1:0] rv;
  int g0, g3;

  initial begin
    m_busy = 0; m_cur = 0; m_ptr = 0; m_cnt = 0;
    e_valid = 0; e_data = 0; e_chan = 0; last_w = -1;
    reset = 1'b1; valid_in = '0; data_in = '0;
    @(posedge clk_2f); #1;

    // reset with all channels valid
    step(1'b1, 4'hF, pack(8'h01, 8'h02, 8'h03, 8'h04));
    step(1'b1, 4'hF, pack(8'h01, 8'h02, 8'h03, 8'h04));
    check("reset valid_out", {31'd0, valid_out}, 32'd0);
    check("reset chan_out", {30'd0, chan_out}, 32'd0);

    // single channel ch2
    step(1'b0, 4'b0100, pack(8'h00, 8'h00, 8'h10, 8'h00));
    check("ch2 word0", {24'd0, data_out}, 32'h10);
    step(1'b0, 4'b0100, pack(8'h00, 8'h00, 8'h11, 8'h00));
    check("ch2 word1", {24'd0, data_out}, 32'h11);
    step(1'b0, 4'b0100, pack(8'h00, 8'h00, 8'h12, 8'h00));
    check("ch2 chan", {30'd0, chan_out}, 32'd2);
    step(1'b0, 4'b0000, '0);
    check("ch2 idle", {31'd0, valid_out}, 32'd0);

    // release without bubble: ch0 burst, ch1 waiting
    step(1'b1, 4'b0000, '0);
    step(1'b0, 4'b0011, pack(8'hA0, 8'hB0, 8'h00, 8'h00));
    step(1'b0, 4'b0011, pack(8'hA1, 8'hB0, 8'h00, 8'h00));
    step(1'b0, 4'b0010, pack(8'h00, 8'hB0, 8'h00, 8'h00));
    check("no bubble data", {24'd0, data_out}, 32'hB0);
    check("no bubble chan", {30'd0, chan_out}, 32'd1);
    step(1'b0, 4'b0000, '0);

    // round-robin fairness with all channels continuously valid
    step(1'b1, 4'b0000, '0);
    g0 = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'hF, pack(8'(8'h20 + i), 8'(8'h40 + i), 8'(8'h60 + i), 8'(8'h80 + i)));
      if (last_w == 0) g0++;
      check("rr valid_out", {31'd0, valid_out}, 32'd1);
    end
    check("rr ch0 grants", 32'(g0), LIM ? 32'd8 : 32'd20);

    // sole channel ch3 for 10 cycles
    step(1'b0, 4'b0000, '0);
    g3 = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'b1000, pack(8'h00, 8'h00, 8'h00, 8'(8'hC0 + i)));
      if (last_w == 3) g3++;
    end
    check("ch3 grants", 32'(g3), 32'd10);
    step(1'b0, 4'b0000, '0);

    // random traffic; held-off words stay stable, occasional reset
    for (int k = 0; k < NCH; k++) begin rd[k] = 8'($urandom); rv[k] = 1'b0; end
    for (int i = 0; i < 400; i++) begin
      logic r;
      r = ($urandom_range(0, 49) == 0);
      step(r, rv, pack(rd[0], rd[1], rd[2], rd[3]));
      for (int k = 0; k < NCH; k++) begin
        if (r || last_w == k || !rv[k]) begin
          rd[k] = 8'($urandom);
          rv[k] = ($urandom_range(0, 3) != 0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
